serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 17 +
 rtl/serial_adder_ctrl_if.sv | 34 +++
 rtl/serial_adder_ctrl_arb.sv | 39 +++
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the serial adder sequencer and its arbiter.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } ctrl_state_t;

    localparam int NUM_REQ = 2;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between two requesters, one consumer and serial_adder_ctrl.
// Optional macro SERIAL_ADDER_CTRL_OVF_EN adds the resp_ovf wrap flag.
interface serial_adder_ctrl_if #(parameter int WIDTH = 4);
    import serial_adder_ctrl_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   req_data0;
    logic [WIDTH-1:0]   req_data1;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [WIDTH-1:0]   resp_data;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic               resp_ovf;
`endif

    modport master (
        output req_valid, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        , input resp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
`ifdef SERIAL_ADDER_CTRL_OVF_EN
        , output resp_ovf
`endif
    );

endinterface

// File: rtl/serial_adder_ctrl_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser on accept.
module rr_arbiter_2
    import serial_adder_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_r;
    logic [NUM_REQ-1:0] grant_s;

    // grant the lone requester, or the pointed-to one on contention
    always_comb begin
        grant_s = 2'b00;
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // priority pointer, points at requester 1 after requester 0 wins and vice versa
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= 1'b0;
        end else if (accept) begin
            ptr_r <= grant_s[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer sharing one bit-serial increment adder between two requesters.
// Optional macro SERIAL_ADDER_CTRL_OVF_EN adds the resp_ovf wrap flag.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_adder_ctrl_if.slave   bus,
    output logic                 ser_reset,
    output logic                 ser_data,
    input  logic                 ser_out,
    output logic                 busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ctrl_state_t        state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [WIDTH-1:0]   op_r, res_r;
    logic               id_r;
    logic               resp_valid_r, ser_reset_r, ser_data_r, busy_r;
    logic               accept_s;
    logic [NUM_REQ-1:0] grant_s, req_ready_s;

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .accept    (accept_s),
        .grant     (grant_s)
    );

    // next-state, bit counter and request accept
    always_comb begin
        state_s     = state_r;
        cnt_s       = '0;
        accept_s    = 1'b0;
        req_ready_s = 2'b00;
        case (state_r)
            IDLE: begin
                req_ready_s = grant_s;
                if (|grant_s) begin
                    accept_s = 1'b1;
                    state_s  = CLEAR;
                end else begin
                    state_s  = IDLE;
                end
            end
            CLEAR: begin
                state_s = SHIFT;
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = RESP;
                end else begin
                    state_s = SHIFT;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // state, datapath and look-ahead registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            op_r         <= '0;
            res_r        <= '0;
            id_r         <= 1'b0;
            resp_valid_r <= 1'b0;
            ser_reset_r  <= 1'b0;
            ser_data_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                op_r <= grant_s[1] ? bus.req_data1 : bus.req_data0;
                id_r <= grant_s[1];
            end
            // result fills from the MSB so the first serial bit ends at bit 0
            if (state_r == SHIFT) begin
                res_r <= {ser_out, res_r[WIDTH-1:1]};
            end
            resp_valid_r <= (state_s == RESP);
            ser_reset_r  <= (state_s != CLEAR);
            ser_data_r   <= (state_s == SHIFT) ? op_r[cnt_s] : 1'b0;
            busy_r       <= (state_s != IDLE);
        end
    end

`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic ovf_r;

    // wrap flag, asserted alongside resp_valid for an all-ones operand
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= (state_s == RESP) ? (&op_r) : 1'b0;
        end
    end

    assign bus.resp_ovf = ovf_r;
`endif

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = id_r;
    assign bus.resp_data  = res_r;
    assign ser_reset      = ser_reset_r;
    assign ser_data       = ser_data_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural serial increment adder.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ser_reset, ser_data, ser_out, busy;
    logic carry = 1'b1;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ser_reset (ser_reset),
        .ser_data  (ser_data),
        .ser_out   (ser_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // serial increment adder: carry-in starts at 1 after a clear
    always @(posedge clk) carry <= !ser_reset ? 1'b1 : (carry & ser_data);
    assign ser_out = ser_data ^ carry;

    int errors = 0;
    int checks = 0;

    // transaction-level reference: age counts cycles since the accepting edge
    int               m_age = 0;
    bit               m_ptr = 1'b0;
    bit               m_id  = 1'b0;
    bit               m_rst_last = 1'b1;
    logic [WIDTH-1:0] m_op = '0;
    int               n_resp = 0;
    int               n_resp_id1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_grant();
        logic [1:0] v;
        v = bus.req_valid;
        if (v == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic check_outputs();
        logic [WIDTH-1:0] sh;
        logic             exp_sd;
        logic [1:0]       exp_rdy;
        sh      = m_op >> (m_age - 2);
        exp_sd  = (m_age >= 2 && m_age <= WIDTH + 1) ? sh[0] : 1'b0;
        exp_rdy = (m_age == 0) ? model_grant() : 2'b00;
        chk("busy",       32'(busy),           32'(m_age != 0));
        chk("ser_reset",  32'(ser_reset),      32'(m_age != 1 && !m_rst_last));
        chk("ser_data",   32'(ser_data),       32'(exp_sd));
        chk("req_ready",  32'(bus.req_ready),  32'(exp_rdy));
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_age == WIDTH + 2));
        if (m_age == WIDTH + 2) begin
            chk("resp_data", 32'(bus.resp_data), 32'(WIDTH'(m_op + 1)));
            chk("resp_id",   32'(bus.resp_id),   32'(m_id));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            chk("resp_ovf",  32'(bus.resp_ovf),  32'(m_op == '1));
`endif
        end
        if (m_rst_last) begin
            chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
            chk("rst_resp_id",   32'(bus.resp_id),   32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            chk("rst_resp_ovf",  32'(bus.resp_ovf),  32'd0);
`endif
        end
    endtask

    task automatic model_edge();
        logic [1:0] g;
        if (!reset) begin
            m_age = 0;
            m_ptr = 1'b0;
            m_rst_last = 1'b1;
        end else begin
            m_rst_last = 1'b0;
            if (m_age == 0) begin
                g = model_grant();
                if (g != 2'b00) begin
                    m_id  = g[1];
                    m_op  = m_id ? bus.req_data1 : bus.req_data0;
                    m_ptr = !m_id;
                    m_age = 1;
                end
            end else if (m_age <= WIDTH + 1) begin
                m_age++;
            end else if (bus.resp_ready) begin
                m_age = 0;
                n_resp++;
                if (m_id) n_resp_id1++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // present one request, drop it once accepted, then run to idle
    task automatic issue(input int which, input logic [WIDTH-1:0] d);
        bit ok;
        if (which == 1) bus.req_data1 = d; else bus.req_data0 = d;
        bus.req_valid = (which == 1) ? 2'b10 : 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            ok = (m_age == 1);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle();
            ok = (m_age == 0);
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // both requesters valid together; each drops after being accepted
    task automatic serve_both(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        bit ok;
        bus.req_data0 = d0;
        bus.req_data1 = d1;
        bus.req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            cycle();
            if (m_age == 1) bus.req_valid[m_id] = 1'b0;
            ok = (bus.req_valid == 2'b00) && (m_age == 0);
        end
        if (!ok) chk("both_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        bit ok;
        bus.req_valid  = 2'b00;
        bus.req_data0  = '0;
        bus.req_data1  = '0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cycle();                       // reset values
        reset = 1'b1;

        issue(0, 4'h5);
        serve_both(4'h3, 4'h7);
        serve_both(4'h1, 4'h2);
        issue(0, 4'hF);
        issue(0, 4'hE);

        // consumer stalls three cycles
        bus.resp_ready = 1'b0;
        bus.req_data1  = 4'hB;
        bus.req_valid  = 2'b10;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cycle();
            if (m_age == 1) bus.req_valid = 2'b00;
            ok = (m_age == WIDTH + 2);
        end
        if (!ok) chk("stall_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        bus.resp_ready = 1'b1;
        cycle();
        chk("stall_done", 32'(m_age), 32'd0);
        cycle();

        // reset during the second SHIFT cycle
        bus.req_data0 = 4'h6;
        bus.req_valid = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cycle();
            if (m_age == 1) bus.req_valid = 2'b00;
            ok = (m_age == 3);
        end
        if (!ok) chk("shift_timeout", 32'd0, 32'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        issue(0, 4'h9);

        // back-to-back sweep on requester 1
        base = n_resp_id1;
        bus.req_valid = 2'b10;
        for (int op = 0; op < 16; op++) begin
            bus.req_data1 = WIDTH'(op);
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                cycle();
                ok = (m_age == 1);
            end
            if (!ok) chk("sweep_timeout", 32'd0, 32'd1);
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < 20 && m_age != 0; i++) cycle();
        chk("sweep_count", 32'(n_resp_id1 - base), 32'd16);

        // randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            bus.req_valid  = 2'($urandom_range(0, 3));
            bus.req_data0  = WIDTH'($urandom);
            bus.req_data1  = WIDTH'($urandom);
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            reset          = ($urandom_range(0, 149) != 0);
            cycle();
        end
        reset = 1'b1;
        chk("responses_seen", 32'(n_resp > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
